// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Grants are held for bursts of up to MAX_BURST beats; FULL stalls without rotating.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(N_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] DI,
  output logic [N_REQ-1:0]       ACK,
  output logic [N_REQ-1:0]       GNT,
  output logic [IW-1:0]          GNT_ID,
  output logic                   BUSY,
  input  logic                   FULL,
  output logic                   W_EN,
  output logic [WIDTH-1:0]       W_DI
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    gnt_id_q;
  logic [IW-1:0]    ptr_q;
  logic [BW-1:0]    bcnt_q;

  logic             found_d;
  logic [IW-1:0]    sel_d;
  logic [IW:0]      idx;
  logic [IW-1:0]    ptr_d;
  logic             own_req;
  logic             wen;
  logic             last_beat;

  // First requester at or after the priority pointer, wrapping.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ))
        idx = idx - (IW+1)'(N_REQ);
      if (!found_d && REQ[idx[IW-1:0]]) begin
        found_d = 1'b1;
        sel_d   = idx[IW-1:0];
      end
    end
  end

  assign own_req   = REQ[gnt_id_q];
  assign wen       = (state_q == S_GRANT) & own_req & ~FULL;
  assign last_beat = wen && (bcnt_q == BW'(MAX_BURST - 1));
  assign ptr_d     = (gnt_id_q == IW'(N_REQ - 1)) ? '0
                                                   : gnt_id_q + 1'b1;

  assign W_EN   = wen;
  assign ACK    = wen ? gnt_q : '0;
  assign W_DI   = wen ? DI[gnt_id_q*WIDTH +: WIDTH] : '0;
  assign GNT    = gnt_q;
  assign GNT_ID = gnt_id_q;
  assign BUSY   = (state_q == S_GRANT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      bcnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q  <= S_GRANT;
            gnt_q    <= N_REQ'(1) << sel_d;
            gnt_id_q <= sel_d;
            bcnt_q   <= '0;
          end
        end
        S_GRANT: begin
          if (!own_req || last_beat) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            bcnt_q  <= '0;
          end else if (wen) begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a MAX_BURST=4 instance and a
// MAX_BURST=1 instance, with requesters advancing their data on ACK.
module tb_fifo_wr_arbiter;

  logic        CLK, RST;
  logic [3:0]  REQ, ACK, GNT;
  logic [1:0]  GNT_ID;
  logic        BUSY, FULL, W_EN;
  logic [7:0]  W_DI;
  logic [31:0] DI;
  logic [7:0]  dat [4];

  logic [3:0]  REQ1, ACK1, GNT1;
  logic [1:0]  GNT_ID1;
  logic        BUSY1, FULL1, W_EN1;
  logic [7:0]  W_DI1;
  logic [31:0] DI1;
  logic [7:0]  dat1 [4];

  int total = 0;
  int bad   = 0;

  assign DI  = {dat[3], dat[2], dat[1], dat[0]};
  assign DI1 = {dat1[3], dat1[2], dat1[1], dat1[0]};

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DI(DI), .ACK(ACK), .GNT(GNT),
    .GNT_ID(GNT_ID), .BUSY(BUSY), .FULL(FULL), .W_EN(W_EN), .W_DI(W_DI)
  );

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ1), .DI(DI1), .ACK(ACK1), .GNT(GNT1),
    .GNT_ID(GNT_ID1), .BUSY(BUSY1), .FULL(FULL1), .W_EN(W_EN1),
    .W_DI(W_DI1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] a, a1;
    a  = ACK;
    a1 = ACK1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (a[k])  dat[k]  = dat[k] + 8'd1;
      if (a1[k]) dat1[k] = dat1[k] + 8'd1;
    end
    #1;
  endtask

  task automatic pulse_rst();
    RST = 1'b1;
    #1;
    RST = 1'b0;
    #1;
  endtask

  // Invariants on both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    chk("inv_gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
    chk("inv_wen", 32'(!W_EN || (BUSY && !FULL)), 32'd1);
    chk("inv_ack_pop", 32'($countones(ACK) <= 1), 32'd1);
    chk("inv_ack_wen", 32'((ACK != 0) == W_EN), 32'd1);
    chk("inv1_gnt_onehot0", 32'($onehot0(GNT1)), 32'd1);
    chk("inv1_wen", 32'(!W_EN1 || (BUSY1 && !FULL1)), 32'd1);
    chk("inv1_ack_wen", 32'((ACK1 != 0) == W_EN1), 32'd1);
  end

  initial begin
    logic [7:0] base [4];
    int         srv  [4];
    int         ord  [5];
    int         g;

    RST = 1'b1; REQ = '0; FULL = 1'b0; REQ1 = '0; FULL1 = 1'b0;
    for (int k = 0; k < 4; k++) begin dat[k] = '0; dat1[k] = '0; end
    #1;
    chk("rst_gnt", GNT, 0);
    chk("rst_gnt_id", GNT_ID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_wen", W_EN, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_wdi", W_DI, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;

    // Single requester bursting, then re-granted after one IDLE cycle.
    dat[1] = 8'h11;
    REQ = 4'b0010;
    #1;
    chk("t1_idle_wen", W_EN, 0);
    tick();
    chk("t1_gnt", GNT, 4'b0010);
    chk("t1_gnt_id", GNT_ID, 1);
    chk("t1_busy", BUSY, 1);
    for (int b = 0; b < 4; b++) begin
      chk("t1_wen", W_EN, 1);
      chk("t1_wdi", W_DI, 8'h11 + b);
      chk("t1_ack", ACK, 4'b0010);
      tick();
    end
    chk("t1_exit_busy", BUSY, 0);
    chk("t1_exit_gnt", GNT, 0);
    chk("t1_exit_wen", W_EN, 0);
    tick();
    chk("t1_regnt", GNT, 4'b0010);
    chk("t1_beat5", W_DI, 8'h15);
    REQ = 4'b0000;
    #1;
    chk("t1_drop_wen", W_EN, 0);
    chk("t1_drop_wdi", W_DI, 0);
    tick();
    chk("t1_drop_busy", BUSY, 0);

    // All requesting: order 0,1,2,3,0 with four beats each.
    pulse_rst();
    base[0] = 8'h00; base[1] = 8'h40; base[2] = 8'h80; base[3] = 8'hC0;
    for (int k = 0; k < 4; k++) begin dat[k] = base[k]; srv[k] = 0; end
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    REQ = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = ord[n];
      tick();
      chk("t2_gnt_id", GNT_ID, g);
      for (int b = 0; b < 4; b++) begin
        chk("t2_wen", W_EN, 1);
        chk("t2_ack", ACK, 32'(1) << g);
        chk("t2_wdi", W_DI, base[g] + 8'(srv[g]));
        srv[g]++;
        tick();
      end
      chk("t2_rot_busy", BUSY, 0);
    end
    REQ = 4'b0000;
    #1;

    // Back-pressure: FULL for 5 cycles after beat 2 of requester 2.
    dat[2] = 8'h50;
    REQ = 4'b0100;
    tick();
    chk("t3_gnt", GNT, 4'b0100);
    for (int b = 0; b < 2; b++) begin
      chk("t3_wdi", W_DI, 8'h50 + b);
      tick();
    end
    FULL = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t3_stall_wen", W_EN, 0);
      chk("t3_stall_ack", ACK, 0);
      chk("t3_stall_gnt", GNT, 4'b0100);
      chk("t3_stall_wdi", W_DI, 0);
      tick();
    end
    FULL = 1'b0;
    #1;
    for (int b = 2; b < 4; b++) begin
      chk("t3_wen", W_EN, 1);
      chk("t3_wdi", W_DI, 8'h50 + b);
      tick();
    end
    chk("t3_rot", BUSY, 0);
    REQ = 4'b0000;
    #1;

    // Early release by requester 0 with requester 3 waiting.
    pulse_rst();
    dat[0] = 8'h60; dat[3] = 8'h70;
    REQ = 4'b1001;
    tick();
    chk("t4_gnt0", GNT, 4'b0001);
    for (int b = 0; b < 2; b++) begin
      chk("t4_wdi0", W_DI, 8'h60 + b);
      tick();
    end
    REQ = 4'b1000;
    #1;
    chk("t4_drop_wen", W_EN, 0);
    chk("t4_drop_ack", ACK, 0);
    tick();
    chk("t4_idle", BUSY, 0);
    tick();
    chk("t4_gnt3", GNT, 4'b1000);
    chk("t4_gnt_id3", GNT_ID, 3);
    for (int b = 0; b < 4; b++) begin
      chk("t4_wdi3", W_DI, 8'h70 + b);
      tick();
    end
    chk("t4_full_burst", BUSY, 0);
    REQ = 4'b0000;
    #1;

    // Asynchronous reset during beat 2 of requester 1.
    dat[1] = 8'h20;
    REQ = 4'b0010;
    tick();
    tick();
    chk("t5_beat2", W_DI, 8'h21);
    RST = 1'b1;
    #1;
    chk("t5_wen", W_EN, 0);
    chk("t5_ack", ACK, 0);
    chk("t5_gnt", GNT, 0);
    chk("t5_busy", BUSY, 0);
    RST = 1'b0;
    REQ = 4'b1111;
    tick();
    chk("t5_first", GNT_ID, 0);
    chk("t5_first_gnt", GNT, 4'b0001);
    REQ = 4'b0000;
    #1;

    // MAX_BURST=1 instance: 0,2,0,2 with an IDLE cycle between beats.
    pulse_rst();
    dat1[0] = 8'h0A; dat1[2] = 8'h2A;
    REQ1 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_gnt_id", GNT_ID1, (i % 2) * 2);
      chk("t6_wen", W_EN1, 1);
      chk("t6_wdi", W_DI1, ((i % 2) ? 8'h2A : 8'h0A) + 8'(i / 2));
      tick();
      chk("t6_idle", BUSY1, 0);
      chk("t6_idle_wen", W_EN1, 0);
    end
    REQ1 = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
